sync_fifo: RTL and testbench
============================

SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- DLY, 1, simulation delay on register assignments.
- DATA_WIDTH, 8, word width.
- FIFO_DEPTH, 32, words; power of two, 4..4096.
- FWFT_EN, 0, 0 = standard read, 1 = first-word-fall-through.
- AFULL_THRESH, FIFO_DEPTH-2, almost-full level.
- AEMPTY_THRESH, 2, almost-empty level.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk_i, in, 1, single clock; all logic on rising edge.
- rst_i, in, 1, reset; asynchronous, active-high.
- wr_en_i, in, 1, write request.
- wr_data_i, in, DATA_WIDTH, write data.
- rd_en_i, in, 1, read request (pop in FWFT).
- rd_data_o, out, DATA_WIDTH, read data.
- rd_valid_o, out, 1, rd_data_o qualifier.
- full_o, out, 1, no free slot.
- empty_o, out, 1, no readable word.
- almost_full_o, out, 1, data_cnt_o >= AFULL_THRESH.
- almost_empty_o, out, 1, data_cnt_o <= AEMPTY_THRESH.
- data_cnt_o, out, AW+1, words accepted and not yet popped.
- overflow_o, out, 1, one-cycle pulse for a rejected write.
- underflow_o, out, 1, one-cycle pulse for a rejected read.

Function
REQ-003 AW SHALL be clog2(FIFO_DEPTH); wr_ptr and rd_ptr SHALL be AW+1-bit binary; the MSB is the wrap bit; the low AW bits address memory.
REQ-004 A write SHALL be accepted iff wr_en_i=1 and full_o=0; a write while full_o=1 SHALL be dropped and pulse overflow_o on the next cycle, even if rd_en_i=1 in the same cycle.
REQ-005 A read SHALL be accepted iff rd_en_i=1 and empty_o=0; otherwise it SHALL pulse underflow_o on the next cycle and leave state unchanged.
REQ-006 data_cnt_o SHALL be registered: +1 on write only, -1 on read only, unchanged on both or neither; range 0..FIFO_DEPTH, never wraps.
REQ-007 full_o SHALL equal (data_cnt_o==FIFO_DEPTH); almost_full_o and almost_empty_o SHALL be registered and consistent with data_cnt_o in the same cycle.
REQ-008 Standard mode (FWFT_EN=0): a read accepted at edge N SHALL present the word on rd_data_o with rd_valid_o=1 after edge N+1 for one cycle; rd_data_o SHALL hold its value otherwise; empty_o SHALL equal (data_cnt_o==0).
REQ-009 FWFT mode (FWFT_EN=1): the head word SHALL sit in an output register.
- rd_valid_o SHALL equal !empty_o.
- A write at edge N into an empty FIFO SHALL make rd_valid_o=1 after edge N+1.
- A pop SHALL load the next word with no bubble when one is stored.
- data_cnt_o SHALL include the output-register word.
REQ-010 Pointer wrap from FIFO_DEPTH-1 to 0 SHALL toggle the wrap bit; order SHALL be preserved across any number of wraps.
REQ-011 Simultaneous read and write while empty: standard mode SHALL accept the write and reject the read (underflow). FWFT mode SHALL do the same; the word appears per REQ-009.
REQ-012 Simultaneous read and write while full SHALL accept the read and reject the write (overflow); data_cnt_o SHALL become FIFO_DEPTH-1.
REQ-013 Parameter checks SHALL stop elaboration when FIFO_DEPTH is not a power of two, or when AFULL_THRESH or AEMPTY_THRESH is outside 1..FIFO_DEPTH-1.

Reset
REQ-014 rst_i=1 SHALL immediately, with no clock, reset the following: pointers 0, data_cnt_o 0, empty_o 1, full_o 0, almost_empty_o 1, almost_full_o 0, rd_valid_o 0, overflow_o 0, underflow_o 0, rd_data_o 0.
REQ-015 Memory contents SHALL NOT be reset; reset mid-operation SHALL discard all stored words; the first write after deassertion SHALL land at address 0.
REQ-016 Requests in the cycle rst_i deasserts SHALL be handled normally from the first rising edge with rst_i=0.

Structure
REQ-017 A shared package fifo_pkg SHALL hold the clog2 function, the FWFT/standard mode constants and the parameter-check macro, for reuse by the async FIFO family.
REQ-018 Storage SHALL be one sub-module, sync_fifo_mem: single-clock simple dual-port RAM, one write port, registered read port, no reset.

Verification
REQ-019 Scenarios (DEPTH=8, AFULL=6, AEMPTY=2, width 8):
- Standard mode: write 0x11,0x22,0x33, then read 3 -> rd_data_o 0x11,0x22,0x33, each one cycle after its rd_en_i, rd_valid_o pulsed; empty_o=1 and data_cnt_o=0 at end.
- Fill 8 words then write 0xAA -> full_o=1, almost_full_o=1 from count 6, overflow_o pulse, count stays 8; read 8 -> 0xAA never appears.
- Full plus simultaneous read and write -> read accepted, write rejected, overflow_o=1, count 7; empty plus read -> underflow_o=1, no count change.
- FWFT mode: write 0x5A to empty -> rd_valid_o=1 and rd_data_o=0x5A after next edge, no rd_en_i needed; back-to-back pops of 4 words give no bubble.
- 20 writes interleaved with reads (2 wraps) -> in-order data, count always within 0..8.
- Assert rst_i with 5 words stored, between clock edges -> all flags and outputs per REQ-014 before the next edge; next write/read returns the new word.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared helpers for the FIFO family: clog2, read-mode encodings and parameter validation.
`ifndef FIFO_PKG_SV
`define FIFO_PKG_SV

// Stops elaboration when a FIFO instance is built with unusable parameters.
`define FIFO_PARAM_CHECK(depth, mode, afull, aempty) \
  if (!fifo_pkg::fifo_params_ok(depth, mode, afull, aempty)) begin : g_param_err \
    $error("fifo parameters rejected: depth=%0d mode=%0d afull=%0d aempty=%0d", depth, mode, afull, aempty); \
  end

package fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  function automatic int fifo_clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

  function automatic bit fifo_params_ok(input int depth, input int mode,
                                        input int afull, input int aempty);
    bit ok;
    ok = (depth >= 4) && (depth <= 4096) && ((depth & (depth - 1)) == 0);
    ok = ok && ((mode == FIFO_MODE_STD) || (mode == FIFO_MODE_FWFT));
    ok = ok && (afull >= 1) && (afull <= depth - 1);
    ok = ok && (aempty >= 1) && (aempty <= depth - 1);
    return ok;
  endfunction

endpackage

`endif

// File: rtl/sync_fifo_mem.sv
// Single-clock simple dual-port RAM with a registered read port; no reset on storage.
module sync_fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [0:(1<<ADDR_WIDTH)-1];
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] rdata_d;

  // Write-first on an address collision so a word can fall straight through an empty FIFO.
  always_comb begin
    rdata_d = rdata_q;
    if (re_i) begin
      if (we_i && (waddr_i == raddr_i)) rdata_d = wdata_i;
      else                              rdata_d = mem_q[raddr_i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= rdata_d;
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo.sv
// Synchronous FIFO with standard or first-word-fall-through read, occupancy count and
// registered almost-full/almost-empty flags.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DLY           = 1,
  parameter int DATA_WIDTH    = 8,
  parameter int FIFO_DEPTH    = 32,
  parameter int FWFT_EN       = 0,
  parameter int AFULL_THRESH  = FIFO_DEPTH - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           wr_en_i,
  input  logic [DATA_WIDTH-1:0]          wr_data_i,
  input  logic                           rd_en_i,
  output logic [DATA_WIDTH-1:0]          rd_data_o,
  output logic                           rd_valid_o,
  output logic                           full_o,
  output logic                           empty_o,
  output logic                           almost_full_o,
  output logic                           almost_empty_o,
  output logic [fifo_clog2(FIFO_DEPTH):0] data_cnt_o,
  output logic                           overflow_o,
  output logic                           underflow_o
);

  localparam int AW = fifo_clog2(FIFO_DEPTH);
  localparam bit FWFT = (FWFT_EN == FIFO_MODE_FWFT);
  localparam logic [AW:0] DEPTH_LVL  = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] AFULL_LVL  = (AW+1)'(AFULL_THRESH);
  localparam logic [AW:0] AEMPTY_LVL = (AW+1)'(AEMPTY_THRESH);
  localparam logic [AW:0] ONE        = (AW+1)'(1);

  `FIFO_PARAM_CHECK(FIFO_DEPTH, FWFT_EN, AFULL_THRESH, AEMPTY_THRESH)

  // DLY only affects simulation timing; the RTL itself uses zero-delay assignments.
  if (DLY < 0) begin : g_dly_err
    $error("sync_fifo: DLY must be non-negative (got %0d)", DLY);
  end

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] cnt_q, cnt_d;
  logic        rd_valid_q, rd_valid_d;
  logic        afull_q, afull_d;
  logic        aempty_q, aempty_d;
  logic        ovf_q, ovf_d;
  logic        udf_q, udf_d;
  logic        out_live_q, out_live_d;

  logic                  full;
  logic                  empty;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  mem_re;
  logic [AW:0]           mem_words;
  logic [DATA_WIDTH-1:0] mem_rdata;

  always_comb begin
    full      = (cnt_q == DEPTH_LVL);
    empty     = (cnt_q == '0);
    wr_acc    = wr_en_i && !full;
    rd_acc    = rd_en_i && !empty;
    mem_words = wr_ptr_q - rd_ptr_q;

    // In FWFT the read port doubles as the head register: refill it whenever it is
    // empty or being popped and a word is stored or arriving.
    if (FWFT) mem_re = (empty || rd_acc) && ((mem_words != '0) || wr_acc);
    else      mem_re = rd_acc;

    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, wr_acc};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, mem_re};

    cnt_d = cnt_q;
    if (wr_acc && !rd_acc)      cnt_d = cnt_q + ONE;
    else if (rd_acc && !wr_acc) cnt_d = cnt_q - ONE;

    rd_valid_d = !FWFT && rd_acc;
    afull_d    = (cnt_d >= AFULL_LVL);
    aempty_d   = (cnt_d <= AEMPTY_LVL);
    ovf_d      = wr_en_i && full;
    udf_d      = rd_en_i && empty;
    out_live_d = out_live_q || mem_re;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      rd_valid_q <= 1'b0;
      afull_q    <= 1'b0;
      aempty_q   <= 1'b1;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      out_live_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      rd_valid_q <= rd_valid_d;
      afull_q    <= afull_d;
      aempty_q   <= aempty_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
      out_live_q <= out_live_d;
    end
  end

  sync_fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(AW)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (wr_data_i),
    .re_i    (mem_re),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (mem_rdata)
  );

  // The RAM read register has no reset, so the output reads zero until it is first loaded.
  assign rd_data_o      = out_live_q ? mem_rdata : '0;
  assign rd_valid_o     = FWFT ? !empty : rd_valid_q;
  assign full_o         = full;
  assign empty_o        = empty;
  assign almost_full_o  = afull_q;
  assign almost_empty_o = aempty_q;
  assign data_cnt_o     = cnt_q;
  assign overflow_o     = ovf_q;
  assign underflow_o    = udf_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench: a standard-mode and an FWFT-mode FIFO (depth 8) share one stimulus stream.
module tb_sync_fifo;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;

  logic [7:0] s_rd_data, f_rd_data;
  logic       s_rd_valid, f_rd_valid;
  logic       s_full, f_full, s_empty, f_empty;
  logic       s_af, f_af, s_ae, f_ae;
  logic [3:0] s_cnt, f_cnt;
  logic       s_ovf, f_ovf, s_udf, f_udf;

  int checks = 0;
  int errors = 0;

  logic [7:0] model_q[$];
  logic [7:0] s_exp_q[$];
  logic [7:0] f_exp_q[$];

  always #5 clk = ~clk;

  sync_fifo #(.DLY(1), .DATA_WIDTH(8), .FIFO_DEPTH(DEPTH), .FWFT_EN(0),
              .AFULL_THRESH(6), .AEMPTY_THRESH(2)) u_std (
    .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_data_i(wr_data), .rd_en_i(rd_en),
    .rd_data_o(s_rd_data), .rd_valid_o(s_rd_valid), .full_o(s_full), .empty_o(s_empty),
    .almost_full_o(s_af), .almost_empty_o(s_ae), .data_cnt_o(s_cnt),
    .overflow_o(s_ovf), .underflow_o(s_udf));

  sync_fifo #(.DLY(1), .DATA_WIDTH(8), .FIFO_DEPTH(DEPTH), .FWFT_EN(1),
              .AFULL_THRESH(6), .AEMPTY_THRESH(2)) u_fwft (
    .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_data_i(wr_data), .rd_en_i(rd_en),
    .rd_data_o(f_rd_data), .rd_valid_o(f_rd_valid), .full_o(f_full), .empty_o(f_empty),
    .almost_full_o(f_af), .almost_empty_o(f_ae), .data_cnt_o(f_cnt),
    .overflow_o(f_ovf), .underflow_o(f_udf));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: standard mode pops on every rd_valid; FWFT compares the head and pops on rd_en.
  always @(negedge clk) begin
    if (s_rd_valid) begin
      chk("s_exp_avail", (s_exp_q.size() != 0), 1);
      if (s_exp_q.size() != 0) chk("s_rd_data", s_rd_data, s_exp_q.pop_front());
    end
    if (f_rd_valid) begin
      chk("f_exp_avail", (f_exp_q.size() != 0), 1);
      if (f_exp_q.size() != 0) begin
        chk("f_head", f_rd_data, f_exp_q[0]);
        if (rd_en) void'(f_exp_q.pop_front());
      end
    end
  end

  task automatic chk_state(input bit ovf, input bit udf, input bit rv);
    int n;
    n = model_q.size();
    chk("s_cnt", s_cnt, n);               chk("f_cnt", f_cnt, n);
    chk("s_full", s_full, n == DEPTH);    chk("f_full", f_full, n == DEPTH);
    chk("s_empty", s_empty, n == 0);      chk("f_empty", f_empty, n == 0);
    chk("s_af", s_af, n >= 6);            chk("f_af", f_af, n >= 6);
    chk("s_ae", s_ae, n <= 2);            chk("f_ae", f_ae, n <= 2);
    chk("s_ovf", s_ovf, ovf);             chk("f_ovf", f_ovf, ovf);
    chk("s_udf", s_udf, udf);             chk("f_udf", f_udf, udf);
    chk("s_rd_valid", s_rd_valid, rv);    chk("f_rd_valid", f_rd_valid, n > 0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_s_cnt"}, s_cnt, 0);       chk({tag, "_f_cnt"}, f_cnt, 0);
    chk({tag, "_s_empty"}, s_empty, 1);   chk({tag, "_f_empty"}, f_empty, 1);
    chk({tag, "_s_full"}, s_full, 0);     chk({tag, "_f_full"}, f_full, 0);
    chk({tag, "_s_ae"}, s_ae, 1);         chk({tag, "_f_ae"}, f_ae, 1);
    chk({tag, "_s_af"}, s_af, 0);         chk({tag, "_f_af"}, f_af, 0);
    chk({tag, "_s_rv"}, s_rd_valid, 0);   chk({tag, "_f_rv"}, f_rd_valid, 0);
    chk({tag, "_s_ovf"}, s_ovf, 0);       chk({tag, "_f_ovf"}, f_ovf, 0);
    chk({tag, "_s_udf"}, s_udf, 0);       chk({tag, "_f_udf"}, f_udf, 0);
    chk({tag, "_s_data"}, s_rd_data, 0);  chk({tag, "_f_data"}, f_rd_data, 0);
  endtask

  // Called shortly after a rising edge; drives one cycle of requests and checks the result.
  task automatic cyc(input bit wr, input logic [7:0] d, input bit rd);
    bit wacc, racc;
    wr_en = wr; wr_data = d; rd_en = rd;
    wacc = wr && (model_q.size() < DEPTH);
    racc = rd && (model_q.size() > 0);
    if (racc) s_exp_q.push_back(model_q.pop_front());
    if (wacc) begin
      model_q.push_back(d);
      f_exp_q.push_back(d);
    end
    @(posedge clk);
    #1;
    chk_state(wr && !wacc, rd && !racc, racc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] nxt [3];
    rst = 1'b1; wr_en = 1'b0; wr_data = '0; rd_en = 1'b0;
    #2 chk_reset("por");
    #10 rst = 1'b0;
    @(posedge clk); #1;

    // Basic standard read latency and FWFT fall-through
    cyc(1, 8'h11, 0);
    chk("f_first_data", f_rd_data, 8'h11);
    cyc(1, 8'h22, 0);
    cyc(1, 8'h33, 0);
    repeat (3) cyc(0, 8'h00, 1);
    cyc(0, 8'h00, 0);
    chk("s_hold", s_rd_data, 8'h33);

    // Fill, overflow, drain
    for (int i = 0; i < 8; i++) begin
      cyc(1, 8'h01 + 8'(i), 0);
      if (i == 5) chk("af_at6", s_af, 1);
      if (i == 4) chk("af_at5", s_af, 0);
    end
    cyc(1, 8'hAA, 0);
    chk("ovf_pulse", s_ovf, 1);
    chk("cnt_full", s_cnt, 8);
    cyc(0, 8'h00, 0);
    chk("ovf_clear", s_ovf, 0);
    repeat (8) cyc(0, 8'h00, 1);

    // Full with simultaneous read and write; then empty read
    for (int i = 0; i < 8; i++) cyc(1, 8'h40 + 8'(i), 0);
    cyc(1, 8'hBB, 1);
    chk("rw_full_ovf", f_ovf, 1);
    chk("rw_full_cnt", f_cnt, 7);
    repeat (7) cyc(0, 8'h00, 1);
    cyc(0, 8'h00, 1);
    chk("empty_udf", s_udf, 1);
    chk("empty_cnt", s_cnt, 0);

    // Empty with simultaneous read and write; FWFT word appears without rd_en
    cyc(1, 8'h5A, 1);
    chk("rw_empty_udf", f_udf, 1);
    chk("fwft_5a_valid", f_rd_valid, 1);
    chk("fwft_5a_data", f_rd_data, 8'h5A);
    cyc(1, 8'h61, 0);
    cyc(1, 8'h62, 0);
    cyc(1, 8'h63, 0);
    nxt[0] = 8'h61; nxt[1] = 8'h62; nxt[2] = 8'h63;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 8'h00, 1);
      chk("fwft_nobubble_valid", f_rd_valid, 1);
      chk("fwft_nobubble_data", f_rd_data, nxt[i]);
    end
    cyc(0, 8'h00, 1);

    // Interleaved traffic across several pointer wraps
    for (int i = 0; i < 20; i++) begin
      cyc(1, 8'h80 + 8'(i), (i % 3) != 0);
      chk("cnt_range", (s_cnt <= 4'd8), 1);
    end
    while (model_q.size() > 0) cyc(0, 8'h00, 1);
    cyc(0, 8'h00, 0);

    // Asynchronous reset between edges with words stored
    for (int i = 0; i < 5; i++) cyc(1, 8'h91 + 8'(i), 0);
    wr_en = 1'b0; rd_en = 1'b0;
    #2 rst = 1'b1;
    #1 chk_reset("mid");
    model_q.delete();
    f_exp_q.delete();
    @(posedge clk);
    #3 rst = 1'b0;
    cyc(1, 8'hC3, 0);
    chk("post_rst_f_data", f_rd_data, 8'hC3);
    cyc(0, 8'h00, 1);
    chk("post_rst_s_data", s_rd_data, 8'hC3);
    cyc(0, 8'h00, 0);
    cyc(0, 8'h00, 0);

    chk("s_exp_drained", s_exp_q.size(), 0);
    chk("f_exp_drained", f_exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
